// File: rtl/mp_port_arbiter_4to2_pkg.sv
// Shared widths and types for the 4-to-2 data-cache port arbiter.
// Imported by the arbiter top and its round-robin picker.
package mp_port_arbiter_4to2_pkg;

  localparam int MEM_ADDR = 12;
  localparam int WORD     = 32;
  localparam int BYTE_EN  = WORD / 8;
  localparam int NUM_REQ  = 4;
  localparam int NUM_PORT = 2;

  typedef logic [1:0] idx_t;

  typedef struct packed {
    logic vld;
    logic rd;
    idx_t idx;
  } tag_t;

endpackage

// File: rtl/mp_rr_pick2.sv
// Round-robin pick of up to two requesters per cycle.
// B skips any requester that conflicts with A.
module mp_rr_pick2
  import mp_port_arbiter_4to2_pkg::*;
(
  input  logic [3:0]      req_i,
  input  idx_t            ptr_i,
  input  logic [3:0][3:0] conf_i,
  output logic            a_vld_o,
  output idx_t            a_idx_o,
  output logic            b_vld_o,
  output idx_t            b_idx_o
);

  idx_t idx;

  always_comb begin
    a_vld_o = 1'b0;
    a_idx_o = '0;
    b_vld_o = 1'b0;
    b_idx_o = '0;
    idx     = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_i + idx_t'(i);
      if (req_i[idx]) begin
        if (!a_vld_o) begin
          a_vld_o = 1'b1;
          a_idx_o = idx;
        end else if (!b_vld_o &&
                     !conf_i[a_idx_o][idx]) begin
          b_vld_o = 1'b1;
          b_idx_o = idx;
        end
      end
    end
  end

endmodule

// File: rtl/mp_port_arbiter_4to2.sv
// Four requesters onto a 2-port data memory, two grants per cycle,
// registered memory drive and tagged read-data return.
module mp_port_arbiter_4to2
  import mp_port_arbiter_4to2_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR,
  parameter int DATA_W = WORD,
  parameter int BE_W   = BYTE_EN,
  parameter int NREQ   = NUM_REQ
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic [NREQ-1:0]                  req_i,
  input  logic [NREQ-1:0]                  we_i,
  input  logic [NREQ-1:0][BE_W-1:0]        be_i,
  input  logic [NREQ-1:0][ADDR_W-1:0]      addr_i,
  input  logic [NREQ-1:0][DATA_W-1:0]      wdata_i,
  output logic [NREQ-1:0]                  gnt_o,
  output logic [NREQ-1:0]                  rvalid_o,
  output logic [NREQ-1:0][DATA_W-1:0]      rdata_o,
  output logic [NUM_PORT-1:0]              mem_we_o,
  output logic [NUM_PORT-1:0][BE_W-1:0]    mem_be_o,
  output logic [NUM_PORT-1:0][ADDR_W-1:0]  mem_addr_o,
  output logic [NUM_PORT-1:0][DATA_W-1:0]  mem_wdata_o,
  input  logic [NUM_PORT-1:0][DATA_W-1:0]  mem_rdata_i
);

  logic [3:0][3:0] conf;
  logic            a_vld, b_vld;
  idx_t            a_idx, b_idx;
  logic [NUM_PORT-1:0]       sel_vld;
  idx_t [NUM_PORT-1:0]       sel_idx;

  idx_t                              ptr_q, ptr_d;
  logic [NUM_PORT-1:0]               we_q, we_d;
  logic [NUM_PORT-1:0][BE_W-1:0]     be_q, be_d;
  logic [NUM_PORT-1:0][ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_PORT-1:0][DATA_W-1:0]   wdata_q, wdata_d;
  tag_t [NUM_PORT-1:0]               tag1_q, tag1_d;
  tag_t [NUM_PORT-1:0]               tag2_q, tag2_d;
  logic [NREQ-1:0]                   rvalid_q, rvalid_d;
  logic [NREQ-1:0][DATA_W-1:0]       rdata_q, rdata_d;

  // Same word with at least one writer must not share a cycle.
  always_comb begin
    conf = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        conf[i][j] = (addr_i[i] == addr_i[j]) &&
                     (we_i[i] || we_i[j]);
      end
    end
  end

  mp_rr_pick2 u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .conf_i  (conf),
    .a_vld_o (a_vld),
    .a_idx_o (a_idx),
    .b_vld_o (b_vld),
    .b_idx_o (b_idx)
  );

  assign sel_vld = {b_vld, a_vld};
  assign sel_idx = {b_idx, a_idx};

  always_comb begin
    gnt_o = '0;
    if (resetn) begin
      if (a_vld) gnt_o[a_idx] = 1'b1;
      if (b_vld) gnt_o[b_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (b_vld) begin
      ptr_d = b_idx + idx_t'(1);
    end else if (a_vld) begin
      ptr_d = a_idx + idx_t'(1);
    end
  end

  // Idle ports keep address/data steady; only we drops.
  always_comb begin
    we_d    = '0;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tag1_d  = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (sel_vld[p]) begin
        we_d[p]    = we_i[sel_idx[p]];
        be_d[p]    = be_i[sel_idx[p]];
        addr_d[p]  = addr_i[sel_idx[p]];
        wdata_d[p] = wdata_i[sel_idx[p]];
      end
      tag1_d[p].vld = sel_vld[p];
      tag1_d[p].rd  = ~we_i[sel_idx[p]];
      tag1_d[p].idx = sel_idx[p];
    end
    tag2_d = tag1_q;
  end

  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (tag2_q[p].vld && tag2_q[p].rd) begin
        rvalid_d[tag2_q[p].idx] = 1'b1;
        rdata_d[tag2_q[p].idx]  = mem_rdata_i[p];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q    <= '0;
      we_q     <= '0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tag1_q   <= '0;
      tag2_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag2_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_mp_port_arbiter_4to2.sv
// Bench for mp_port_arbiter_4to2: memory model, reference arbiter
// model checked every cycle, plus scheduled literal checks.
module tb_mp_port_arbiter_4to2;

  logic clock = 1'b0;
  logic resetn;
  logic [3:0]        req_i, we_i;
  logic [3:0][3:0]   be_i;
  logic [3:0][11:0]  addr_i;
  logic [3:0][31:0]  wdata_i;
  logic [3:0]        gnt_o, rvalid_o;
  logic [3:0][31:0]  rdata_o;
  logic [1:0]        mem_we_o;
  logic [1:0][3:0]   mem_be_o;
  logic [1:0][11:0]  mem_addr_o;
  logic [1:0][31:0]  mem_wdata_o;
  logic [1:0][31:0]  mem_rdata_i;

  always #5 clock = ~clock;

  mp_port_arbiter_4to2 dut (
    .clock       (clock),
    .resetn      (resetn),
    .req_i       (req_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  function automatic logic [31:0] pat(int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Environment memory: synchronous read, byte-masked write
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [4096];
  bit          mfill;

  always @(posedge clock) begin
    if (!mfill) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
      mfill <= 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        mem_rdata_i[p] <= mem[mem_addr_o[p]];
        if (mem_we_o[p])
          for (int b = 0; b < 4; b++)
            if (mem_be_o[p][b])
              mem[mem_addr_o[p]][8*b+:8] <= mem_wdata_o[p][8*b+:8];
      end
      if (pre_en) mem[pre_addr] <= pre_data;
    end
  end

  typedef struct {
    int          due;
    int          k;
    logic [31:0] d;
  } pend_t;

  typedef struct {
    int          cyc;
    int          what;
    int          k;
    logic [31:0] v;
    string       nm;
  } lit_t;

  lit_t        lits[$];
  pend_t       pend[$];
  logic [31:0] gmem [4096];
  bit          gfill;
  int          cyc;
  int          m_ptr;
  int          n_cmp;
  int          n_bad;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: grants are in program order, so a read returns
  // the value of the golden memory at the moment it is granted.
  always @(negedge clock) begin
    int          a, b, k, g;
    logic [3:0]  eg, erv;
    logic [3:0][31:0] erd;
    if (!gfill) begin
      for (int i = 0; i < 4096; i++) gmem[i] = pat(i);
      gfill = 1'b1;
    end
    if (!resetn) begin
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_rvalid", 32'(rvalid_o), 32'd0);
      chk("rst_mem_we", 32'(mem_we_o), 32'd0);
      m_ptr = 0;
      pend.delete();
    end else begin
      a = -1;
      b = -1;
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr + i) % 4;
        if (req_i[k]) begin
          if (a < 0) a = k;
          else if (b < 0 && !(addr_i[a] == addr_i[k] &&
                              (we_i[a] || we_i[k]))) b = k;
        end
      end
      eg = '0;
      if (a >= 0) eg[a] = 1'b1;
      if (b >= 0) eg[b] = 1'b1;
      chk("gnt", 32'(gnt_o), 32'(eg));
      erv = '0;
      erd = '0;
      foreach (pend[i])
        if (pend[i].due == cyc) begin
          erv[pend[i].k] = 1'b1;
          erd[pend[i].k] = pend[i].d;
        end
      chk("rvalid", 32'(rvalid_o), 32'(erv));
      for (int i = 0; i < 4; i++)
        if (erv[i]) chk("rdata", rdata_o[i], erd[i]);
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due <= cyc) pend.delete(i);
      for (int s = 0; s < 2; s++) begin
        g = (s == 0) ? a : b;
        if (g >= 0) begin
          if (we_i[g]) begin
            for (int bb = 0; bb < 4; bb++)
              if (be_i[g][bb])
                gmem[addr_i[g]][8*bb+:8] = wdata_i[g][8*bb+:8];
          end else begin
            pend.push_back('{cyc + 3, g, gmem[addr_i[g]]});
          end
        end
      end
      if (b >= 0) m_ptr = (b + 1) % 4;
      else if (a >= 0) m_ptr = (a + 1) % 4;
    end
    if (pre_en) gmem[pre_addr] = pre_data;
    foreach (lits[i])
      if (lits[i].cyc == cyc)
        case (lits[i].what)
          0: chk(lits[i].nm, 32'(gnt_o), lits[i].v);
          1: chk(lits[i].nm, 32'(rvalid_o), lits[i].v);
          2: chk(lits[i].nm, rdata_o[lits[i].k], lits[i].v);
          3: chk(lits[i].nm, 32'(mem_addr_o[lits[i].k]), lits[i].v);
          4: chk(lits[i].nm, 32'(mem_we_o), lits[i].v);
          5: chk(lits[i].nm, 32'(mem_be_o[lits[i].k]), lits[i].v);
          6: chk(lits[i].nm, mem_wdata_o[lits[i].k], lits[i].v);
          default: ;
        endcase
    cyc++;
  end

  // Called just after a rising edge, when cyc names the current cycle.
  task automatic lit(int dc, int what, int k, logic [31:0] v, string nm);
    lits.push_back('{cyc + dc, what, k, v, nm});
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic preload(logic [11:0] a, logic [31:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick(1);
    pre_en   = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_i  = '0;
    we_i   = '0;
    tick(2);
    resetn = 1'b1;
  endtask

  initial begin
    resetn   = 1'b0;
    req_i    = '0;
    we_i     = '0;
    be_i     = '0;
    addr_i   = '0;
    wdata_i  = '0;
    pre_en   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    tick(2);
    preload(12'h010, 32'hAAAA0001);
    preload(12'h020, 32'hBBBB0002);
    preload(12'h100, 32'h12345678);

    // reset then idle
    do_reset();
    lit(0, 0, 0, 32'h0, "idle_gnt");
    lit(1, 1, 0, 32'h0, "idle_rvalid");
    lit(1, 4, 0, 32'h0, "idle_mem_we");
    lit(1, 3, 0, 32'h0, "idle_mem_addr0");
    lit(1, 2, 0, 32'h0, "idle_rdata0");
    tick(3);

    // dual read
    do_reset();
    req_i     = 4'b0101;
    addr_i[0] = 12'h010;
    addr_i[2] = 12'h020;
    lit(0, 0, 0, 32'h5, "dual_gnt");
    lit(1, 3, 0, 32'h010, "dual_addr0");
    lit(1, 3, 1, 32'h020, "dual_addr1");
    lit(3, 1, 0, 32'h5, "dual_rvalid");
    lit(3, 2, 0, 32'hAAAA0001, "dual_rdata0");
    lit(3, 2, 2, 32'hBBBB0002, "dual_rdata2");
    tick(1);
    req_i = '0;
    tick(5);

    // round robin, all four continuously
    do_reset();
    for (int k = 0; k < 4; k++) addr_i[k] = 12'h200 + 12'(k);
    req_i = 4'b1111;
    lit(0, 0, 0, 32'h3, "rr_c0");
    lit(1, 0, 0, 32'hC, "rr_c1");
    lit(2, 0, 0, 32'h3, "rr_c2");
    lit(3, 0, 0, 32'hC, "rr_c3");
    lit(3, 2, 1, pat(12'h201), "rr_rdata1");
    tick(6);
    req_i = '0;
    tick(5);

    // write/write hazard on one word
    do_reset();
    req_i      = 4'b1010;
    we_i       = 4'b1010;
    be_i[1]    = 4'hF;
    be_i[3]    = 4'hF;
    addr_i[1]  = 12'h040;
    addr_i[3]  = 12'h040;
    wdata_i[1] = 32'h11111111;
    wdata_i[3] = 32'h22222222;
    lit(0, 0, 0, 32'h2, "ww_first");
    lit(1, 0, 0, 32'h8, "ww_second");
    lit(1, 4, 0, 32'h1, "ww_mem_we");
    lit(1, 6, 0, 32'h11111111, "ww_wdata0");
    tick(1);
    req_i[1] = 1'b0;
    tick(1);
    req_i     = 4'b0001;
    we_i      = '0;
    addr_i[0] = 12'h040;
    lit(3, 2, 0, 32'h22222222, "ww_final_read");
    tick(1);
    req_i = '0;
    tick(5);

    // partial byte-enable write then read back
    do_reset();
    req_i      = 4'b0001;
    we_i       = 4'b0001;
    addr_i[0]  = 12'h100;
    be_i[0]    = 4'b0010;
    wdata_i[0] = 32'h0000AB00;
    lit(1, 5, 0, 32'h2, "be_mem_be");
    tick(1);
    we_i = '0;
    lit(3, 2, 0, 32'h1234AB78, "be_read");
    tick(1);
    req_i = '0;
    tick(5);

    // reset one cycle after granting a read
    do_reset();
    req_i      = 4'b0011;
    we_i       = 4'b0010;
    addr_i[0]  = 12'h010;
    addr_i[1]  = 12'h300;
    be_i[1]    = 4'hF;
    wdata_i[1] = 32'hDEADBEEF;
    lit(0, 0, 0, 32'h3, "mid_gnt");
    tick(1);
    req_i  = '0;
    we_i   = '0;
    resetn = 1'b0;
    lit(0, 4, 0, 32'h0, "mid_mem_we");
    lit(2, 1, 0, 32'h0, "mid_no_rvalid");
    tick(2);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) addr_i[k] = 12'h200 + 12'(k);
    req_i = 4'b1111;
    lit(0, 0, 0, 32'h3, "mid_ptr0");
    lit(1, 1, 0, 32'h0, "mid_rvalid_after");
    tick(1);
    req_i = '0;
    tick(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
